// File: rtl/mfp_ahb_ram_arbiter_pkg.sv
// Shared AHB-Lite encodings and master index constants for the RAM arbiter.
package mfp_ahb_ram_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic MFP_AHB_ARB_M0 = 1'b0;
    localparam logic MFP_AHB_ARB_M1 = 1'b1;

    // SEQ/BUSY mean the current owner is mid-burst and must keep the bus.
    function automatic logic htrans_in_burst(input logic [1:0] htrans);
        return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/mfp_ahb_arb_grant.sv
// Combinational grant decision for the two-master RAM arbiter.
// Optional: MFP_AHB_ARB_ROUND_ROBIN_EN alternates masters on a tie.
module mfp_ahb_arb_grant
    import mfp_ahb_ram_arbiter_pkg::*;
#(
    parameter int PARK_MASTER = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_hold,
    input  logic i_cur_owner,
    input  logic i_last_grant,
    output logic o_grant
);

    localparam logic LP_PARK = 1'(PARK_MASTER);

    logic w_tie_winner;

`ifdef MFP_AHB_ARB_ROUND_ROBIN_EN
    assign w_tie_winner = ~i_last_grant;
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
    assign w_tie_winner        = MFP_AHB_ARB_M0;
`endif

    always_comb begin
        o_grant = LP_PARK;
        if (i_hold)
            o_grant = i_cur_owner;
        else if (i_req0 && !i_req1)
            o_grant = MFP_AHB_ARB_M0;
        else if (i_req1 && !i_req0)
            o_grant = MFP_AHB_ARB_M1;
        else if (i_req0 && i_req1)
            o_grant = w_tie_winner;
    end

endmodule

// File: rtl/mfp_ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-cycle RAM slave.
// Optional: MFP_AHB_ARB_ROUND_ROBIN_EN (handled in mfp_ahb_arb_grant).
module mfp_ahb_ram_arbiter
    import mfp_ahb_ram_arbiter_pkg::*;
#(
    parameter int PARK_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [2:0]  M0_HBURST,
    input  logic        M0_HMASTLOCK,
    input  logic [3:0]  M0_HPROT,
    input  logic [2:0]  M0_HSIZE,
    input  logic [1:0]  M0_HTRANS,
    input  logic [31:0] M0_HWDATA,
    input  logic        M0_HWRITE,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [2:0]  M1_HBURST,
    input  logic        M1_HMASTLOCK,
    input  logic [3:0]  M1_HPROT,
    input  logic [2:0]  M1_HSIZE,
    input  logic [1:0]  M1_HTRANS,
    input  logic [31:0] M1_HWDATA,
    input  logic        M1_HWRITE,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] S_HADDR,
    output logic [2:0]  S_HBURST,
    output logic        S_HMASTLOCK,
    output logic [3:0]  S_HPROT,
    output logic [2:0]  S_HSIZE,
    output logic [1:0]  S_HTRANS,
    output logic [31:0] S_HWDATA,
    output logic        S_HWRITE,
    output logic        S_HSEL,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADY,
    input  logic        S_HRESP
);

    localparam logic LP_PARK = 1'(PARK_MASTER);

    logic r_addr_owner;
    logic r_data_owner;
    logic r_data_active;
    logic r_last_grant;

    logic w_req0;
    logic w_req1;
    logic w_hold;
    logic w_grant;
    logic w_m0_dphase;
    logic w_m1_dphase;

    assign w_req0 = (M0_HTRANS != HTRANS_IDLE);
    assign w_req1 = (M1_HTRANS != HTRANS_IDLE);
    assign w_hold = r_addr_owner ? (htrans_in_burst(M1_HTRANS) | M1_HMASTLOCK)
                                 : (htrans_in_burst(M0_HTRANS) | M0_HMASTLOCK);

    // A slave stall freezes the grant just like a burst hold does.
    mfp_ahb_arb_grant #(.PARK_MASTER(PARK_MASTER)) u_grant (
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_hold       (w_hold | ~S_HREADY),
        .i_cur_owner  (r_addr_owner),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_comb begin
        S_HADDR     = w_grant ? M1_HADDR     : M0_HADDR;
        S_HBURST    = w_grant ? M1_HBURST    : M0_HBURST;
        S_HMASTLOCK = w_grant ? M1_HMASTLOCK : M0_HMASTLOCK;
        S_HPROT     = w_grant ? M1_HPROT     : M0_HPROT;
        S_HSIZE     = w_grant ? M1_HSIZE     : M0_HSIZE;
        S_HTRANS    = w_grant ? M1_HTRANS    : M0_HTRANS;
        S_HWRITE    = w_grant ? M1_HWRITE    : M0_HWRITE;
    end

    assign S_HSEL    = 1'b1;
    assign S_HWDATA  = r_data_owner ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    assign w_m0_dphase = r_data_active && (r_data_owner == MFP_AHB_ARB_M0);
    assign w_m1_dphase = r_data_active && (r_data_owner == MFP_AHB_ARB_M1);

    // Engaged masters track the slave; a requesting loser is stalled.
    assign M0_HREADY = (w_m0_dphase || (w_grant == MFP_AHB_ARB_M0)) ? S_HREADY : ~w_req0;
    assign M1_HREADY = (w_m1_dphase || (w_grant == MFP_AHB_ARB_M1)) ? S_HREADY : ~w_req1;
    assign M0_HRESP  = w_m0_dphase & S_HRESP;
    assign M1_HRESP  = w_m1_dphase & S_HRESP;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr_owner  <= LP_PARK;
            r_data_owner  <= MFP_AHB_ARB_M0;
            r_data_active <= 1'b0;
            r_last_grant  <= MFP_AHB_ARB_M1;
        end else if (S_HREADY) begin
            r_addr_owner  <= w_grant;
            r_data_owner  <= w_grant;
            r_data_active <= (S_HTRANS != HTRANS_IDLE);
            if (!w_hold && (S_HTRANS == HTRANS_NONSEQ))
                r_last_grant <= w_grant;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_ram_arbiter.sv
// Directed bench for mfp_ahb_ram_arbiter: per-cycle model compare plus literal checks.
module tb_mfp_ahb_ram_arbiter;

    localparam int PARK = 0;

    logic        HCLK, HRESET;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic [2:0]  M0_HBURST, M1_HBURST, M0_HSIZE, M1_HSIZE;
    logic        M0_HMASTLOCK, M1_HMASTLOCK, M0_HWRITE, M1_HWRITE;
    logic [3:0]  M0_HPROT, M1_HPROT;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [2:0]  S_HBURST, S_HSIZE;
    logic        S_HMASTLOCK, S_HWRITE, S_HSEL, S_HREADY, S_HRESP;
    logic [3:0]  S_HPROT;
    logic [1:0]  S_HTRANS;

    int checks = 0;
    int failures = 0;

    mfp_ahb_ram_arbiter #(.PARK_MASTER(PARK)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HBURST(M0_HBURST), .M0_HMASTLOCK(M0_HMASTLOCK),
        .M0_HPROT(M0_HPROT), .M0_HSIZE(M0_HSIZE), .M0_HTRANS(M0_HTRANS),
        .M0_HWDATA(M0_HWDATA), .M0_HWRITE(M0_HWRITE), .M0_HRDATA(M0_HRDATA),
        .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
        .M1_HADDR(M1_HADDR), .M1_HBURST(M1_HBURST), .M1_HMASTLOCK(M1_HMASTLOCK),
        .M1_HPROT(M1_HPROT), .M1_HSIZE(M1_HSIZE), .M1_HTRANS(M1_HTRANS),
        .M1_HWDATA(M1_HWDATA), .M1_HWRITE(M1_HWRITE), .M1_HRDATA(M1_HRDATA),
        .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
        .S_HADDR(S_HADDR), .S_HBURST(S_HBURST), .S_HMASTLOCK(S_HMASTLOCK),
        .S_HPROT(S_HPROT), .S_HSIZE(S_HSIZE), .S_HTRANS(S_HTRANS),
        .S_HWDATA(S_HWDATA), .S_HWRITE(S_HWRITE), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_owner;      // master whose address phase is on the bus
    int  m_dp_master;  // master whose data phase is pending, -1 if none
    int  m_recent;     // master that last won a fresh arbitration
    bit  m_valid = 0;

    function automatic logic [1:0] trans_of(input int m);
        return (m == 1) ? M1_HTRANS : M0_HTRANS;
    endfunction

    function automatic bit wants(input int m);
        return trans_of(m) != 2'b00;
    endfunction

    function automatic bit keeps_bus(input int m);
        logic lk;
        lk = (m == 1) ? M1_HMASTLOCK : M0_HMASTLOCK;
        return (trans_of(m) == 2'b11) || (trans_of(m) == 2'b01) || lk;
    endfunction

    function automatic int winner();
        if (!S_HREADY || keeps_bus(m_owner)) return m_owner;
        if (wants(0) && wants(1)) begin
`ifdef MFP_AHB_ARB_ROUND_ROBIN_EN
            return 1 - m_recent;
`else
            return 0;
`endif
        end
        if (wants(0)) return 0;
        if (wants(1)) return 1;
        return PARK;
    endfunction

    function automatic logic exp_ready(input int m);
        if (m_dp_master == m || winner() == m) return S_HREADY;
        return !wants(m);
    endfunction

    always @(posedge HCLK) begin
        int g;
        if (HRESET) begin
            m_owner = PARK; m_dp_master = -1; m_recent = 1; m_valid = 1;
        end else if (S_HREADY) begin
            g = winner();
            if (!keeps_bus(m_owner) && trans_of(g) == 2'b10) m_recent = g;
            m_owner = g;
            m_dp_master = wants(g) ? g : -1;
        end
    end

    always @(negedge HCLK) begin
        int g;
        if (m_valid) begin
            g = winner();
            check("S_addr_ctrl", {S_HADDR, S_HBURST, S_HMASTLOCK, S_HPROT, S_HSIZE, S_HTRANS, S_HWRITE},
                  (g == 1) ? {M1_HADDR, M1_HBURST, M1_HMASTLOCK, M1_HPROT, M1_HSIZE, M1_HTRANS, M1_HWRITE}
                           : {M0_HADDR, M0_HBURST, M0_HMASTLOCK, M0_HPROT, M0_HSIZE, M0_HTRANS, M0_HWRITE});
            if (m_dp_master >= 0)
                check("S_HWDATA", S_HWDATA, (m_dp_master == 1) ? M1_HWDATA : M0_HWDATA);
            check("S_HSEL", S_HSEL, 1'b1);
            check("M0_HREADY", M0_HREADY, exp_ready(0));
            check("M1_HREADY", M1_HREADY, exp_ready(1));
            check("M0_HRESP", M0_HRESP, (m_dp_master == 0) && S_HRESP);
            check("M1_HRESP", M1_HRESP, (m_dp_master == 1) && S_HRESP);
            check("HRDATA", {M0_HRDATA, M1_HRDATA}, {S_HRDATA, S_HRDATA});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] burst, input logic lk);
        if (m == 0) begin
            M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HBURST = burst; M0_HMASTLOCK = lk;
        end else begin
            M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HBURST = burst; M1_HMASTLOCK = lk;
        end
    endtask

    int exp_seq[6];

    initial begin
        HRESET = 1'b1; S_HREADY = 1'b1; S_HRESP = 1'b0; S_HRDATA = 32'h0;
        M0_HPROT = 4'h3; M1_HPROT = 4'hA; M0_HSIZE = 3'd2; M1_HSIZE = 3'd1;
        M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick(); tick();
        #1;
        check("rst_S_HTRANS", S_HTRANS, 2'b00);
        check("rst_M0_HREADY", M0_HREADY, 1'b1);
        check("rst_M1_HREADY", M1_HREADY, 1'b1);
        check("rst_HRESP", {M0_HRESP, M1_HRESP}, 2'b00);

        // Single M0 read
        HRESET = 1'b0;
        drv(0, 2'b10, 32'h10, 1'b0, 3'd0, 1'b0);
        #1;
        check("t1_S_HADDR", S_HADDR, 32'h10);
        check("t1_M0_HREADY", M0_HREADY, 1'b1);
        check("t1_M1_HREADY", M1_HREADY, 1'b1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        S_HRDATA = 32'h1234_5678;
        #1;
        check("t1_M0_HRDATA", M0_HRDATA, 32'h1234_5678);
        check("t1_M0_HREADY_dp", M0_HREADY, 1'b1);
        tick();

        // Simultaneous NONSEQ: M0 write 0x20, M1 read 0x24
        drv(0, 2'b10, 32'h20, 1'b1, 3'd0, 1'b0);
        drv(1, 2'b10, 32'h24, 1'b0, 3'd0, 1'b0);
        #1;
        check("t2_S_HADDR_m0", S_HADDR, 32'h20);
        check("t2_M1_stall", M1_HREADY, 1'b0);
        check("t2_M0_HREADY", M0_HREADY, 1'b1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        M0_HWDATA = 32'hA5A5_A5A5;
        #1;
        check("t2_S_HADDR_m1", S_HADDR, 32'h24);
        check("t2_S_HWDATA", S_HWDATA, 32'hA5A5_A5A5);
        check("t2_M1_HREADY", M1_HREADY, 1'b1);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();

        // M1 INCR4 burst, M0 arrives during beat 2
        drv(1, 2'b10, 32'h40, 1'b0, 3'd3, 1'b0);
        #1;
        check("t3_beat1", S_HADDR, 32'h40);
        tick();
        drv(1, 2'b11, 32'h44, 1'b0, 3'd3, 1'b0);
        drv(0, 2'b10, 32'h80, 1'b0, 3'd0, 1'b0);
        #1;
        check("t3_beat2", S_HADDR, 32'h44);
        check("t3_M0_stall2", M0_HREADY, 1'b0);
        tick();
        drv(1, 2'b11, 32'h48, 1'b0, 3'd3, 1'b0);
        #1;
        check("t3_M0_stall3", M0_HREADY, 1'b0);
        tick();
        drv(1, 2'b11, 32'h4C, 1'b0, 3'd3, 1'b0);
        #1;
        check("t3_beat4", S_HADDR, 32'h4C);
        check("t3_M0_stall4", M0_HREADY, 1'b0);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        check("t3_M0_granted", S_HADDR, 32'h80);
        check("t3_M0_HREADY", M0_HREADY, 1'b1);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();

        // Locked write/read by M0 with a slave read-after-write stall
        drv(0, 2'b10, 32'h8, 1'b1, 3'd0, 1'b1);
        drv(1, 2'b10, 32'h30, 1'b0, 3'd0, 1'b0);
        #1;
        check("t4_write", S_HADDR, 32'h8);
        check("t4_M1_stall_a", M1_HREADY, 1'b0);
        tick();
        drv(0, 2'b10, 32'h8, 1'b0, 3'd0, 1'b1);
        M0_HWDATA = 32'hDEAD_BEEF;
        S_HREADY = 1'b0;
        #1;
        check("t4_M0_slave_stall", M0_HREADY, 1'b0);
        check("t4_M1_stall_b", M1_HREADY, 1'b0);
        check("t4_S_HWDATA", S_HWDATA, 32'hDEAD_BEEF);
        tick();
        S_HREADY = 1'b1;
        #1;
        check("t4_read", {S_HADDR, S_HWRITE}, {32'h8, 1'b0});
        check("t4_M0_resume", M0_HREADY, 1'b1);
        check("t4_M1_stall_c", M1_HREADY, 1'b0);
        tick();
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        check("t4_M1_granted", S_HADDR, 32'h30);
        tick();
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        S_HRESP = 1'b1;
        #1;
        check("t4_HRESP_route", {M0_HRESP, M1_HRESP}, 2'b01);
        tick();
        S_HRESP = 1'b0;

        // Continuous contention for six transfers
`ifdef MFP_AHB_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        drv(0, 2'b10, 32'h100, 1'b0, 3'd0, 1'b0);
        drv(1, 2'b10, 32'h200, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t5_grant%0d", i), S_HADDR, (exp_seq[i] == 1) ? 32'h200 : 32'h100);
            tick();
        end
        drv(0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();

        // Reset in the middle of an M1 burst
        drv(1, 2'b10, 32'h40, 1'b0, 3'd3, 1'b0);
        tick();
        drv(1, 2'b11, 32'h44, 1'b0, 3'd3, 1'b0);
        tick();
        drv(1, 2'b11, 32'h48, 1'b0, 3'd3, 1'b0);
        S_HRESP = 1'b1;
        HRESET = 1'b1;
        #1;
        check("t6_pre_M1_HRESP", M1_HRESP, 1'b1);
        tick();
        HRESET = 1'b0;
        drv(1, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        check("t6_HRESP", {M0_HRESP, M1_HRESP}, 2'b00);
        check("t6_S_HTRANS", S_HTRANS, 2'b00);
        check("t6_M1_HREADY", M1_HREADY, 1'b1);
        tick();
        S_HRESP = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
